cla_stream_accumulator: RTL

//   Sequential front-end for the combinational 64-bit CLA adder (nbit_CLA_full_adder).

---
 rtl/cla_stream_accumulator.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cla_stream_accumulator.sv
// Streams operands through a 64-bit carry-lookahead adder, accumulating a per-packet
// total (WIDTH-bit sum + carry count + operand count) held on a valid/ready output.

module nbit_CLA_full_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; group generate/propagate chain the group carries.
  always_comb begin
    logic [WIDTH:0] cv;
    logic           grp_g;
    logic           grp_p;
    cv    = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    cv[0] = cin;
    for (int k = 0; k < NG; k++) begin
      cv[4*k+1] = g[4*k] | (p[4*k] & cv[4*k]);
      cv[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                | (p[4*k+1] & p[4*k] & cv[4*k]);
      cv[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                | (p[4*k+2] & p[4*k+1] & g[4*k])
                | (p[4*k+2] & p[4*k+1] & p[4*k] & cv[4*k]);
      grp_g = g[4*k+3] | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      cv[4*k+4] = grp_g | (grp_p & cv[4*k]);
    end
    c = cv;
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];
endmodule

module cla_stream_accumulator #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carries,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic {ACC, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] carries_q, carries_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  nbit_CLA_full_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carries_d   = carries_q;
    count_d     = count_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_sum     = '0;
    out_carries = '0;
    out_count   = '0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d     = add_sum;
          carries_d = (&carries_q) ? carries_q : carries_q + CNT_W'(add_cout);
          count_d   = (&count_q) ? count_q : count_q + CNT_W'(1);
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid   = 1'b1;
        out_sum     = acc_q;
        out_carries = carries_q;
        out_count   = count_q;
        // Clear on handshake; in_ready only returns next cycle (no bypass).
        if (out_ready) begin
          acc_d     = '0;
          carries_d = '0;
          count_d   = '0;
          state_d   = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      carries_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      carries_q <= carries_d;
      count_q   <= count_d;
    end
  end
endmodule
